// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state type, width constants and helpers for router_arbiter
package router_pkg;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} hold_state_t;

  localparam int unsigned DEF_NBITS   = 8;
  localparam int unsigned DEF_NINPUTS = 4;
  localparam int unsigned STATS_W     = 16;

  // Source-index field width; a single input still needs one bit of tag.
  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tag_w(input int unsigned nbits, input int unsigned n);
    return nbits + src_w(n);
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// rtl/rr_priority_sel.sv - one-hot round-robin grant: first set req bit at or above ptr, wrapping
module rr_priority_sel #(
  parameter int unsigned p_n  = 4,
  parameter int unsigned p_pw = 2
) (
  input  logic [p_n-1:0]  req,
  input  logic [p_pw-1:0] ptr,
  output logic [p_n-1:0]  grant
);

  logic            w_found;
  logic [p_pw-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < p_n; k++) begin
      w_idx = p_pw'((32'(ptr) + k) % p_n);
      if (req[w_idx] && !w_found) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_arbiter.sv
// rtl/router_arbiter.sv - round-robin N:1 arbiter with one-deep tagged holding register
// Optional ROUTER_ARBITER_STATS_EN adds a saturating 16-bit delivered-message counter.
module router_arbiter
  import router_pkg::*;
#(
  parameter int unsigned p_nbits   = DEF_NBITS,
  parameter int unsigned p_ninputs = DEF_NINPUTS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [p_ninputs-1:0]                 in_val,
  input  logic [p_ninputs*p_nbits-1:0]         in_msg,
  output logic [p_ninputs-1:0]                 in_rdy,
  output logic                                 out_val,
  output logic [p_nbits+$clog2(p_ninputs)-1:0] out_msg,
  input  logic                                 out_rdy
`ifdef ROUTER_ARBITER_STATS_EN
  ,
  output logic [STATS_W-1:0]                   msg_count
`endif
);

  localparam int unsigned c_sw = src_w(p_ninputs);
  localparam int unsigned c_mw = tag_w(p_nbits, p_ninputs);

  hold_state_t         r_state;
  logic [c_mw-1:0]     r_out_msg;
  logic [c_sw-1:0]     r_ptr;

  logic                w_can_load;
  logic [p_ninputs-1:0] w_grant;
  logic [c_sw-1:0]     w_src;
  logic [p_nbits-1:0]  w_payload;
  logic                w_hs;

  rr_priority_sel #(
    .p_n  (p_ninputs),
    .p_pw (c_sw)
  ) u_sel (
    .req   (in_val),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign w_can_load = (r_state == ST_EMPTY) || out_rdy;
  assign in_rdy     = (reset || !w_can_load) ? '0 : w_grant;
  assign w_hs       = |(in_val & in_rdy);

  // Payload only feeds the register, so in_msg never reaches an output combinationally.
  always_comb begin
    w_src     = '0;
    w_payload = '0;
    for (int unsigned i = 0; i < p_ninputs; i++) begin
      if (w_grant[i]) begin
        w_src     = c_sw'(i);
        w_payload = in_msg[i*p_nbits +: p_nbits];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_out_msg <= '0;
      r_ptr     <= '0;
    end else if (w_hs) begin
      r_state   <= ST_FULL;
      r_out_msg <= {w_src, w_payload};
      r_ptr     <= (w_src == c_sw'(p_ninputs - 1)) ? '0 : w_src + c_sw'(1);
    end else if ((r_state == ST_FULL) && out_rdy) begin
      r_state   <= ST_EMPTY;
    end
  end

  assign out_val = (r_state == ST_FULL);
  assign out_msg = r_out_msg;

`ifdef ROUTER_ARBITER_STATS_EN
  logic [STATS_W-1:0] r_msg_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg_count <= '0;
    end else if (out_val && out_rdy && (r_msg_count != '1)) begin
      r_msg_count <= r_msg_count + STATS_W'(1);
    end
  end

  assign msg_count = r_msg_count;
`endif

endmodule

// File: tb/tb_router_arbiter.sv
// tb/tb_router_arbiter.sv - randomized and directed self-checking bench for router_arbiter
module tb_router_arbiter;

  localparam int N  = 4;
  localparam int NB = 8;
  localparam int SW = 2;
  localparam int MW = NB + SW;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_val;
  logic [N*NB-1:0] in_msg;
  logic [N-1:0]  in_rdy;
  logic          out_val;
  logic [MW-1:0] out_msg;
  logic          out_rdy;
`ifdef ROUTER_ARBITER_STATS_EN
  logic [15:0]   msg_count;
`endif

  router_arbiter #(.p_nbits(NB), .p_ninputs(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_msg  (in_msg),
    .in_rdy  (in_rdy),
    .out_val (out_val),
    .out_msg (out_msg),
    .out_rdy (out_rdy)
`ifdef ROUTER_ARBITER_STATS_EN
    ,
    .msg_count (msg_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: optional held message, integer pointer, counters.
  bit            m_full = 1'b0;
  logic [MW-1:0] m_msg  = '0;
  int            m_ptr  = 0;
  int unsigned   m_cnt  = 0;
  int            m_acc  = 0;
  int            dut_deliv = 0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    int g;
    if (reset) return '0;
    if (m_full && !out_rdy) return '0;
    g = pick(in_val, m_ptr);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_full = 1'b0;
      m_msg  = '0;
      m_ptr  = 0;
      m_cnt  = 0;
    end else begin
      int g;
      bit out_hs;
      out_hs = m_full && out_rdy;
      if (out_hs && m_cnt < 32'hFFFF) m_cnt++;
      g = (m_full && !out_rdy) ? -1 : pick(in_val, m_ptr);
      if (g >= 0) begin
        m_msg  = {SW'(g), in_msg[g*NB +: NB]};
        m_full = 1'b1;
        m_ptr  = (g + 1) % N;
        m_acc++;
      end else if (out_hs) begin
        m_full = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, mid-way between active edges.
  always @(negedge clk) begin
    #2;
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy()));
    chk("out_val", 32'(out_val), 32'(m_full));
    if (reset || m_full) chk("out_msg", 32'(out_msg), 32'(m_msg));
`ifdef ROUTER_ARBITER_STATS_EN
    chk("msg_count", 32'(msg_count), m_cnt);
`endif
    if (!reset && out_val && out_rdy) dut_deliv++;
  end

  task automatic cyc(input logic [N-1:0] v, input logic [N*NB-1:0] m, input logic o);
    @(negedge clk);
    in_val  = v;
    in_msg  = m;
    out_rdy = o;
    #3;
  endtask

  initial begin
    int a0, d0;
    reset = 1'b1; in_val = 4'b1111; in_msg = '0; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_out_val", 32'(out_val), 32'h0);
    chk("rst_out_msg", 32'(out_msg), 32'h0);
    chk("rst_in_rdy",  32'(in_rdy),  32'h0);
    @(negedge clk);
    reset = 1'b0; in_val = '0;

    // simultaneous drain and fill
    cyc(4'b0010, 32'h0000_1100, 1'b0);
    chk("df_rdy1", 32'(in_rdy), 32'h2);
    cyc(4'b0100, 32'h0022_0000, 1'b1);
    chk("df_held", 32'(out_msg), 32'h111);
    chk("df_rdy2", 32'(in_rdy), 32'h4);
    cyc(4'b0000, 32'h0, 1'b1);
    chk("df_msg", 32'(out_msg), 32'h222);
    chk("df_val", 32'(out_val), 32'h1);
    cyc(4'b0000, 32'h0, 1'b1);
    chk("df_empty", 32'(out_val), 32'h0);

    // wrap and skip from ptr=3
    cyc(4'b0101, 32'h00A2_00A0, 1'b1);
    chk("wrap_rdy0", 32'(in_rdy), 32'h1);
    cyc(4'b0101, 32'h00A2_00A0, 1'b1);
    chk("wrap_msg0", 32'(out_msg), 32'h0A0);
    chk("wrap_rdy2", 32'(in_rdy), 32'h4);
    cyc(4'b0000, 32'h0, 1'b1);
    chk("wrap_msg2", 32'(out_msg), 32'h2A2);

    // backpressure
    cyc(4'b1111, 32'h4C3B_2A19, 1'b0);
    chk("bp_grant3", 32'(in_rdy), 32'h8);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 32'h4C3B_2A19, 1'b0);
      chk("bp_msg", 32'(out_msg), 32'h34C);
      chk("bp_rdy", 32'(in_rdy), 32'h0);
    end

    // fairness with all requesting
    cyc(4'b1111, 32'h1312_1110, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 32'h1312_1110, 1'b1);
      chk("fair_src", 32'(out_msg), 32'((k % 4) * 256 + 16 + (k % 4)));
    end

    // asynchronous reset while FULL
    cyc(4'b0100, 32'h00A5_0000, 1'b1);
    cyc(4'b1111, 32'h0, 1'b0);
    chk("pre_rst_msg", 32'(out_msg), 32'h2A5);
    #1 reset = 1'b1;
    #1;
    chk("arst_val", 32'(out_val), 32'h0);
    chk("arst_msg", 32'(out_msg), 32'h0);
    chk("arst_rdy", 32'(in_rdy), 32'h0);
    @(negedge clk);
    reset = 1'b0; in_val = '0;
    cyc(4'b1111, 32'h0403_0201, 1'b1);
    chk("post_rst_ptr0", 32'(in_rdy), 32'h1);

    // randomized traffic
    a0 = m_acc; d0 = dut_deliv;
    for (int k = 0; k < 3000; k++) begin
      cyc(4'($urandom), $urandom, ($urandom_range(0, 9) < 7));
    end
    cyc(4'b0000, 32'h0, 1'b1);
    cyc(4'b0000, 32'h0, 1'b1);
    chk("conservation", 32'(dut_deliv - d0), 32'(m_acc - a0));

`ifdef ROUTER_ARBITER_STATS_EN
    for (int k = 0; k < 70000; k++) cyc(4'b1111, $urandom, 1'b1);
    chk("stats_sat", 32'(msg_count), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
